// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
// Two combinational read ports and one synchronous byte-masked write port.
// Optional write-to-read bypass and hardwired-zero register 0.
// A bulk-clear engine zeroes one register per cycle with a busy/done handshake.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     raddr1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                cnt_last;
    logic                wr_zero_hit;
    logic                wr_commit;
    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   wr_merged;

    assign cnt_last    = (cnt_q == ADDR_W'(DEPTH - 1));
    assign wr_zero_hit = ZERO_REG && (waddr == '0);

    // A write commits only from idle and never in the cycle a clear is accepted.
    assign wr_commit = we && (state_q == StIdle) && !clr_req && (|wbe) && !wr_zero_hit;

    // Byte-merge new data over the currently stored word.
    always_comb begin
        wr_old    = mem_q[waddr];
        wr_merged = wr_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (wbe[i]) begin
                wr_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Clear FSM next-state: walk cnt over every address, then pulse done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_last) begin
                    // Exit instead of wrapping the counter.
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear FSM state, counter and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Storage: reset and clear both zero; clear has priority over writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == StClear) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_commit) begin
            mem_q[waddr] <= wr_merged;
        end
    end

    // Read port 1: zero register, then bypass, then stored value.
    always_comb begin
        rdata1 = mem_q[raddr1];
        if (ZERO_REG && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (BYPASS && wr_commit && (raddr1 == waddr)) begin
            rdata1 = wr_merged;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rdata2 = mem_q[raddr2];
        if (ZERO_REG && (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (BYPASS && wr_commit && (raddr2 == waddr)) begin
            rdata2 = wr_merged;
        end
    end

    assign clr_busy = (state_q == StClear);
    assign clr_done = done_q;

endmodule
